// File: rtl/alu_pkg.sv
// Shared opcode map, strobe bit indices and FSM encoding for the ALU op sequencer.
package alu_pkg;

    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpShr  = 5'b00101;
    localparam logic [4:0] OpShra = 5'b00110;
    localparam logic [4:0] OpShl  = 5'b00111;
    localparam logic [4:0] OpRor  = 5'b01000;
    localparam logic [4:0] OpRol  = 5'b01001;
    localparam logic [4:0] OpAnd  = 5'b01010;
    localparam logic [4:0] OpOr   = 5'b01011;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;

    localparam int unsigned SelAdd  = 0;
    localparam int unsigned SelSub  = 1;
    localparam int unsigned SelMul  = 2;
    localparam int unsigned SelDiv  = 3;
    localparam int unsigned SelAnd  = 4;
    localparam int unsigned SelOr   = 5;
    localparam int unsigned SelShr  = 6;
    localparam int unsigned SelShra = 7;
    localparam int unsigned SelShl  = 8;
    localparam int unsigned SelRor  = 9;
    localparam int unsigned SelRol  = 10;
    localparam int unsigned SelNeg  = 11;
    localparam int unsigned SelNot  = 12;
    localparam int unsigned NumSel  = 13;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StWb   = 2'd2,
        StErr  = 2'd3
    } state_e;

    function automatic logic is_muldiv(input logic [4:0] opcode);
        return (opcode == OpMul) || (opcode == OpDiv);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Issue, ALU-strobe and writeback signals of the op sequencer; slave is the sequencer side.
interface alu_op_sequencer_if;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  opcode;
    logic [31:0] ra_val;
    logic [31:0] rb_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [12:0] alu_sel;
    logic [31:0] alu_chigh;
    logic [31:0] alu_clow;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_hilo;
    logic        illegal;

    modport master (
        output op_valid, opcode, ra_val, rb_val, alu_chigh, alu_clow, res_ready,
        input  op_ready, alu_a, alu_b, alu_sel, res_valid, res_hi, res_lo, res_hilo, illegal
    );

    modport slave (
        input  op_valid, opcode, ra_val, rb_val, alu_chigh, alu_clow, res_ready,
        output op_ready, alu_a, alu_b, alu_sel, res_valid, res_hi, res_lo, res_hilo, illegal
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: legality, one-hot ALU strobe and MUL/DIV flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [4:0]        opcode_i,
    output logic              legal_o,
    output logic [NumSel-1:0] sel_o,
    output logic              muldiv_o
);

    always_comb begin
        legal_o = 1'b1;
        sel_o   = '0;
        case (opcode_i)
            OpAdd:   sel_o[SelAdd]  = 1'b1;
            OpSub:   sel_o[SelSub]  = 1'b1;
            OpShr:   sel_o[SelShr]  = 1'b1;
            OpShra:  sel_o[SelShra] = 1'b1;
            OpShl:   sel_o[SelShl]  = 1'b1;
            OpRor:   sel_o[SelRor]  = 1'b1;
            OpRol:   sel_o[SelRol]  = 1'b1;
            OpAnd:   sel_o[SelAnd]  = 1'b1;
            OpOr:    sel_o[SelOr]   = 1'b1;
            OpMul:   sel_o[SelMul]  = 1'b1;
            OpDiv:   sel_o[SelDiv]  = 1'b1;
            OpNeg:   sel_o[SelNeg]  = 1'b1;
            OpNot:   sel_o[SelNot]  = 1'b1;
            default: legal_o = 1'b0;
        endcase
    end

    assign muldiv_o = is_muldiv(opcode_i);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage around the combinational ALU: latch operands, strobe one op for a
// settle window, capture the 64-bit result and hand it to writeback.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned MULDIV_SETTLE = 4
) (
    input logic               clk,
    input logic               clr_n,
    alu_op_sequencer_if.slave bus
);

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] MulDivLoad = 4'(MULDIV_SETTLE - 1);

    state_e      state_q, state_d;
    logic [31:0] y_q, y_d;
    logic [31:0] b_q, b_d;
    logic [63:0] z_q, z_d;
    logic [4:0]  opc_q, opc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        hilo_q, hilo_d;

    logic              op_ready;
    logic              res_valid;
    logic              illegal;
    logic [NumSel-1:0] alu_sel;

    // One decoder serves both the offered opcode (in IDLE) and the latched one (afterwards).
    logic [4:0]        dec_opc;
    logic              dec_legal;
    logic [NumSel-1:0] dec_sel;
    logic              dec_muldiv;

    assign dec_opc = (state_q == StIdle) ? bus.opcode : opc_q;

    alu_op_decode u_decode (
        .opcode_i (dec_opc),
        .legal_o  (dec_legal),
        .sel_o    (dec_sel),
        .muldiv_o (dec_muldiv)
    );

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        b_d       = b_q;
        z_d       = z_q;
        opc_d     = opc_q;
        cnt_d     = cnt_q;
        hilo_d    = hilo_q;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        illegal   = 1'b0;
        alu_sel   = '0;
        case (state_q)
            StIdle: begin
                op_ready = 1'b1;
                if (bus.op_valid) begin
                    y_d     = bus.ra_val;
                    b_d     = bus.rb_val;
                    opc_d   = bus.opcode;
                    cnt_d   = dec_muldiv ? MulDivLoad : SettleLoad;
                    state_d = dec_legal ? StExec : StErr;
                end
            end
            StExec: begin
                alu_sel = dec_sel;
                if (cnt_q == 4'd0) begin
                    z_d     = {bus.alu_chigh, bus.alu_clow};
                    hilo_d  = dec_muldiv;
                    state_d = StWb;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWb: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                illegal = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= StIdle;
            y_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            opc_q   <= '0;
            cnt_q   <= '0;
            hilo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            b_q     <= b_d;
            z_q     <= z_d;
            opc_q   <= opc_d;
            cnt_q   <= cnt_d;
            hilo_q  <= hilo_d;
        end
    end

    assign bus.op_ready  = op_ready;
    assign bus.alu_a     = y_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_sel   = alu_sel;
    assign bus.res_valid = res_valid;
    assign bus.res_hi    = z_q[63:32];
    assign bus.res_lo    = z_q[31:0];
    assign bus.res_hilo  = hilo_q;
    assign bus.illegal   = illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table plus backpressure, illegal and reset cases.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if bus ();

    alu_op_sequencer u_dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int nchk = 0;
    int nerr = 0;

    // Stub ALU; single-cycle ops put a marker in the high word to prove raw 64-bit capture.
    logic [31:0] sa, sb;
    always_comb begin
        sa = bus.alu_a;
        sb = bus.alu_b;
        bus.alu_chigh = 32'hA5A5_0000;
        bus.alu_clow  = 32'h0;
        case (1'b1)
            bus.alu_sel[SelAdd]:  bus.alu_clow = sa + sb;
            bus.alu_sel[SelSub]:  bus.alu_clow = sa - sb;
            bus.alu_sel[SelAnd]:  bus.alu_clow = sa & sb;
            bus.alu_sel[SelOr]:   bus.alu_clow = sa | sb;
            bus.alu_sel[SelShr]:  bus.alu_clow = sa >> sb[4:0];
            bus.alu_sel[SelShra]: bus.alu_clow = $signed(sa) >>> sb[4:0];
            bus.alu_sel[SelShl]:  bus.alu_clow = sa << sb[4:0];
            bus.alu_sel[SelRor]:  bus.alu_clow = 32'(({sa, sa} >> sb[4:0]));
            bus.alu_sel[SelRol]:  bus.alu_clow = (({sa, sa} << sb[4:0]) >> 32);
            bus.alu_sel[SelNeg]:  bus.alu_clow = -sa;
            bus.alu_sel[SelNot]:  bus.alu_clow = ~sa;
            bus.alu_sel[SelMul]: begin
                bus.alu_chigh = 32'h1;
                bus.alu_clow  = 32'h2;
            end
            bus.alu_sel[SelDiv]: begin
                bus.alu_chigh = (sb == 0) ? 32'h0 : sa % sb;
                bus.alu_clow  = (sb == 0) ? 32'h0 : sa / sb;
            end
            default: bus.alu_chigh = 32'h0;
        endcase
    end

    typedef struct {
        logic [4:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        hilo;
        int          n;
        int          bitn;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.opcode   = opc;
        bus.ra_val   = a;
        bus.rb_val   = b;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
    endtask

    // Counts strobe cycles after the accept edge until res_valid shows (0 = timed out).
    task automatic observe(output int strobes, output int lat, output logic [12:0] sel_or,
                           output int multi);
        strobes = 0;
        lat     = 0;
        sel_or  = '0;
        multi   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.alu_sel != 13'd0) begin
                strobes++;
                sel_or |= bus.alu_sel;
                if (!$onehot(bus.alu_sel)) multi++;
            end
            if (bus.res_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_ready"}, 64'(bus.op_ready), 64'd1);
        check({tag, "_alu_sel"}, 64'(bus.alu_sel), 64'd0);
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_res_hilo"}, 64'(bus.res_hilo), 64'd0);
        check({tag, "_illegal"}, 64'(bus.illegal), 64'd0);
        check({tag, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 64'd0);
        check({tag, "_res"}, {bus.res_hi, bus.res_lo}, 64'd0);
    endtask

    initial begin
        int          strobes, lat, multi;
        logic [12:0] sel_or, exp_sel;
        logic [4:0]  bad_ops[2];

        vecs[0]  = '{OpAdd,  32'd5,          32'd7,          32'hA5A5_0000, 32'd12,         1'b0, 1, SelAdd};
        vecs[1]  = '{OpSub,  32'd10,         32'd3,          32'hA5A5_0000, 32'd7,          1'b0, 1, SelSub};
        vecs[2]  = '{OpRor,  32'h0000_00F1,  32'd4,          32'hA5A5_0000, 32'h1000_000F,  1'b0, 1, SelRor};
        vecs[3]  = '{OpRol,  32'h8000_0001,  32'd1,          32'hA5A5_0000, 32'h0000_0003,  1'b0, 1, SelRol};
        vecs[4]  = '{OpAnd,  32'hF0F0_1234,  32'h0FF0_FFFF,  32'hA5A5_0000, 32'h00F0_1234,  1'b0, 1, SelAnd};
        vecs[5]  = '{OpOr,   32'hF000_0000,  32'h0000_000F,  32'hA5A5_0000, 32'hF000_000F,  1'b0, 1, SelOr};
        vecs[6]  = '{OpShr,  32'h8000_0000,  32'd31,         32'hA5A5_0000, 32'h0000_0001,  1'b0, 1, SelShr};
        vecs[7]  = '{OpShra, 32'h8000_0000,  32'd4,          32'hA5A5_0000, 32'hF800_0000,  1'b0, 1, SelShra};
        vecs[8]  = '{OpShl,  32'd3,          32'd4,          32'hA5A5_0000, 32'h0000_0030,  1'b0, 1, SelShl};
        vecs[9]  = '{OpNeg,  32'd1,          32'd0,          32'hA5A5_0000, 32'hFFFF_FFFF,  1'b0, 1, SelNeg};
        vecs[10] = '{OpNot,  32'h0F0F_0F0F,  32'd0,          32'hA5A5_0000, 32'hF0F0_F0F0,  1'b0, 1, SelNot};
        vecs[11] = '{OpMul,  32'd6,          32'd9,          32'h0000_0001, 32'h0000_0002,  1'b1, 4, SelMul};
        vecs[12] = '{OpDiv,  32'd100,        32'd7,          32'h0000_0002, 32'h0000_000E,  1'b1, 4, SelDiv};

        bus.op_valid  = 1'b0;
        bus.opcode    = '0;
        bus.ra_val    = '0;
        bus.rb_val    = '0;
        bus.res_ready = 1'b1;

        #12 check_reset_outputs("reset");
        clr_n = 1'b1;
        @(negedge clk);

        // Back-to-back with res_ready tied high: each accept lands N+2 cycles after the last.
        for (int i = 0; i < 13; i++) begin
            check($sformatf("v%0d_op_ready", i), 64'(bus.op_ready), 64'd1);
            issue(vecs[i].opc, vecs[i].a, vecs[i].b);
            observe(strobes, lat, sel_or, multi);
            exp_sel = '0;
            exp_sel[vecs[i].bitn] = 1'b1;
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].n + 1));
            check($sformatf("v%0d_strobes", i), 64'(strobes), 64'(vecs[i].n));
            check($sformatf("v%0d_sel", i), 64'(sel_or), 64'(exp_sel));
            check($sformatf("v%0d_onehot", i), 64'(multi), 64'd0);
            check($sformatf("v%0d_res", i), {bus.res_hi, bus.res_lo}, {vecs[i].hi, vecs[i].lo});
            check($sformatf("v%0d_hilo", i), 64'(bus.res_hilo), 64'(vecs[i].hilo));
            @(negedge clk);
        end

        // Backpressure with a new op held on the input throughout.
        bus.res_ready = 1'b0;
        issue(OpAdd, 32'd20, 32'd22);
        observe(strobes, lat, sel_or, multi);
        check("bp_latency", 64'(lat), 64'd2);
        check("bp_res_lo", 64'(bus.res_lo), 64'd42);
        bus.op_valid = 1'b1;
        bus.opcode   = OpSub;
        bus.ra_val   = 32'd9;
        bus.rb_val   = 32'd4;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_res_valid", k), 64'(bus.res_valid), 64'd1);
            check($sformatf("bp%0d_res", k), {bus.res_hi, bus.res_lo}, {32'hA5A5_0000, 32'd42});
            check($sformatf("bp%0d_op_ready", k), 64'(bus.op_ready), 64'd0);
            check($sformatf("bp%0d_alu_sel", k), 64'(bus.alu_sel), 64'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_op_ready", 64'(bus.op_ready), 64'd1);
        check("bp_release_res_valid", 64'(bus.res_valid), 64'd0);
        check("bp_release_alu_sel", 64'(bus.alu_sel), 64'd0);
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        observe(strobes, lat, sel_or, multi);
        check("bp_next_latency", 64'(lat), 64'd2);
        check("bp_next_sel", 64'(sel_or), 64'(13'd1 << SelSub));
        check("bp_next_res_lo", 64'(bus.res_lo), 64'd5);
        @(negedge clk);

        bad_ops[0] = 5'b00000;
        bad_ops[1] = 5'b11111;
        for (int j = 0; j < 2; j++) begin
            issue(bad_ops[j], 32'd1, 32'd2);
            @(negedge clk);
            check($sformatf("ill%0d_pulse", j), 64'(bus.illegal), 64'd1);
            check($sformatf("ill%0d_op_ready_low", j), 64'(bus.op_ready), 64'd0);
            check($sformatf("ill%0d_sel", j), 64'(bus.alu_sel), 64'd0);
            check($sformatf("ill%0d_res_valid", j), 64'(bus.res_valid), 64'd0);
            @(negedge clk);
            check($sformatf("ill%0d_pulse_end", j), 64'(bus.illegal), 64'd0);
            check($sformatf("ill%0d_op_ready", j), 64'(bus.op_ready), 64'd1);
            check($sformatf("ill%0d_res_valid2", j), 64'(bus.res_valid), 64'd0);
            check($sformatf("ill%0d_sel2", j), 64'(bus.alu_sel), 64'd0);
        end

        // Asynchronous reset in the middle of a DIV settle window.
        issue(OpDiv, 32'd100, 32'd7);
        @(negedge clk);
        check("rst_div_sel", 64'(bus.alu_sel), 64'(13'd1 << SelDiv));
        #2 clr_n = 1'b0;
        #1 check_reset_outputs("midrst");
        #4 clr_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("postrst%0d_res_valid", k), 64'(bus.res_valid), 64'd0);
            check($sformatf("postrst%0d_op_ready", k), 64'(bus.op_ready), 64'd1);
        end
        issue(OpDiv, 32'd100, 32'd7);
        observe(strobes, lat, sel_or, multi);
        check("postrst_div_latency", 64'(lat), 64'd5);
        check("postrst_div_res", {bus.res_hi, bus.res_lo}, {32'd2, 32'd14});
        check("postrst_div_hilo", 64'(bus.res_hilo), 64'd1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
